// File: rtl/demux_1a4_lanes_if.sv
// Serial-side input and rebuilt four-lane output bundle for demux_1a4_lanes.
interface demux_1a4_lanes_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Entrada;
    logic             validEntrada;
    logic [WIDTH-1:0] Salida0;
    logic [WIDTH-1:0] Salida1;
    logic [WIDTH-1:0] Salida2;
    logic [WIDTH-1:0] Salida3;
    logic             validSalida0;
    logic             validSalida1;
    logic             validSalida2;
    logic             validSalida3;
    logic             frame_strobe;

    modport master (
        output Entrada, validEntrada,
        input  Salida0, Salida1, Salida2, Salida3,
        input  validSalida0, validSalida1, validSalida2, validSalida3,
        input  frame_strobe
    );

    modport slave (
        input  Entrada, validEntrada,
        output Salida0, Salida1, Salida2, Salida3,
        output validSalida0, validSalida1, validSalida2, validSalida3,
        output frame_strobe
    );
endinterface

// File: rtl/demux_1a4_lanes.sv
// Rebuilds four parallel lanes from a time-slotted serial byte stream;
// lanes 0..2 are buffered and all four are published together at slot 3.
module demux_1a4_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic               clk_4f,
    input  logic               reset,
    demux_1a4_lanes_if.slave   lanes
);
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    slot_t            slot;
    slot_t            slot_next;
    logic [WIDTH-1:0] lane_buf  [LANES-1];
    logic             lane_vbuf [LANES-1];
    logic [WIDTH-1:0] data_in;

    // Invalid bytes are forced to zero so they never leak onto a lane.
    assign data_in = lanes.validEntrada ? lanes.Entrada : '0;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            slot <= SLOT0;
        end else begin
            slot <= slot_next;
        end
    end

    always_comb begin
        slot_next = slot;
        case (slot)
            SLOT0:   slot_next = SLOT1;
            SLOT1:   slot_next = SLOT2;
            SLOT2:   slot_next = SLOT3;
            SLOT3:   slot_next = SLOT0;
            default: slot_next = SLOT0;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            lane_buf           <= '{default: '0};
            lane_vbuf          <= '{default: 1'b0};
            lanes.Salida0      <= '0;
            lanes.Salida1      <= '0;
            lanes.Salida2      <= '0;
            lanes.Salida3      <= '0;
            lanes.validSalida0 <= 1'b0;
            lanes.validSalida1 <= 1'b0;
            lanes.validSalida2 <= 1'b0;
            lanes.validSalida3 <= 1'b0;
            lanes.frame_strobe <= 1'b0;
        end else begin
            lanes.frame_strobe <= (slot == SLOT3);
            case (slot)
                SLOT0: begin
                    lane_buf[0]  <= data_in;
                    lane_vbuf[0] <= lanes.validEntrada;
                end
                SLOT1: begin
                    lane_buf[1]  <= data_in;
                    lane_vbuf[1] <= lanes.validEntrada;
                end
                SLOT2: begin
                    lane_buf[2]  <= data_in;
                    lane_vbuf[2] <= lanes.validEntrada;
                end
                default: begin
                    // Lane 3 bypasses the buffer and is published in its own slot.
                    lanes.Salida0      <= lane_buf[0];
                    lanes.Salida1      <= lane_buf[1];
                    lanes.Salida2      <= lane_buf[2];
                    lanes.Salida3      <= data_in;
                    lanes.validSalida0 <= lane_vbuf[0];
                    lanes.validSalida1 <= lane_vbuf[1];
                    lanes.validSalida2 <= lane_vbuf[2];
                    lanes.validSalida3 <= lanes.validEntrada;
                end
            endcase
        end
    end
endmodule
